// File: rtl/ascon_block_packer_pkg.sv
// Shared constants, state encoding and lane mapping for the Ascon rate-block packer.
package ascon_block_packer_pkg;

  localparam logic [7:0] PAD_BYTE   = 8'h01;
  localparam int         RATE_BYTES = 16;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } packer_state_e;

  // Stream bytes 0..7 land in S0 (upper half), bytes 8..15 in S1; each half is little-endian.
  function automatic logic [6:0] lane_sel(input logic [3:0] idx);
    lane_sel = {~idx[3], idx[2:0], 3'b000};
  endfunction

endpackage

// File: rtl/ascon_block_packer_if.sv
// Byte-stream input and 128-bit block output handshakes of the block packer.
interface ascon_block_packer_if #(
  parameter int IN_BYTES = 4
);

  logic [8*IN_BYTES-1:0] s_data;
  logic [IN_BYTES-1:0]   s_keep;
  logic                  s_last;
  logic                  s_valid;
  logic                  s_ready;

  logic [127:0]          blk_data;
  logic [4:0]            blk_nbytes;
  logic                  blk_last;
  logic                  blk_valid;
  logic                  blk_ready;

  modport master (
    output s_data, s_keep, s_last, s_valid,
    input  s_ready,
    input  blk_data, blk_nbytes, blk_last, blk_valid,
    output blk_ready
  );

  modport slave (
    input  s_data, s_keep, s_last, s_valid,
    output s_ready,
    output blk_data, blk_nbytes, blk_last, blk_valid,
    input  blk_ready
  );

endinterface

// File: rtl/ascon_block_packer.sv
// Packs a narrow byte stream into padded 128-bit Ascon rate blocks; the accumulator
// doubles as the block output register.
module ascon_block_packer
  import ascon_block_packer_pkg::*;
#(
  parameter int IN_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  ascon_block_packer_if.slave  bus
);

  localparam logic [4:0] RATE_CNT = 5'(RATE_BYTES);

  packer_state_e state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [127:0]  acc_q, acc_d;
  logic [4:0]    nbytes_q, nbytes_d;
  logic          last_q, last_d;
  logic          pad_pend_q, pad_pend_d;

  logic [4:0]    n_s;
  logic [4:0]    cnt_sum_s;
  logic [127:0]  acc_fill_s;
  logic          accept_s;
  logic          blk_take_s;

  assign bus.s_ready    = (state_q == FILL) && !rst;
  assign bus.blk_valid  = (state_q == FULL);
  assign bus.blk_data   = acc_q;
  assign bus.blk_nbytes = nbytes_q;
  assign bus.blk_last   = last_q;

  assign accept_s   = bus.s_valid && bus.s_ready;
  assign blk_take_s = (state_q == FULL) && bus.blk_ready;

  // Byte count of the incoming word and the fill level after it.
  always_comb begin
    n_s = 5'd0;
    for (int j = 0; j < IN_BYTES; j++) begin
      n_s = n_s + {4'b0000, bus.s_keep[j]};
    end
    cnt_sum_s = cnt_q + n_s;
  end

  // Accumulator image after merging the incoming word (and the pad byte on a short final word).
  always_comb begin
    acc_fill_s = acc_q;
    for (int k = 0; k < RATE_BYTES; k++) begin
      for (int j = 0; j < IN_BYTES; j++) begin
        acc_fill_s[lane_sel(4'(k)) +: 8] =
          (bus.s_keep[j] && ((int'(cnt_q) + j) == k)) ? bus.s_data[8*j +: 8]
                                                     : acc_fill_s[lane_sel(4'(k)) +: 8];
      end
    end
    if (bus.s_last && (cnt_sum_s < RATE_CNT)) begin
      acc_fill_s[lane_sel(cnt_sum_s[3:0]) +: 8] = PAD_BYTE;
    end else begin
      acc_fill_s = acc_fill_s;
    end
  end

  // Next-state logic; clear_i overrides any handshake in the same cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    nbytes_d   = nbytes_q;
    last_d     = last_q;
    pad_pend_d = pad_pend_q;

    if (clear_i) begin
      state_d    = FILL;
      cnt_d      = 5'd0;
      acc_d      = 128'd0;
      nbytes_d   = 5'd0;
      last_d     = 1'b0;
      pad_pend_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept_s) begin
            acc_d = acc_fill_s;
            cnt_d = cnt_sum_s;
            if (bus.s_last) begin
              state_d = FULL;
              if (cnt_sum_s < RATE_CNT) begin
                nbytes_d = cnt_sum_s;
                last_d   = 1'b1;
              end else begin
                // Exactly full final block: padding goes in a follow-up block.
                nbytes_d   = RATE_CNT;
                last_d     = 1'b0;
                pad_pend_d = 1'b1;
              end
            end else if (cnt_sum_s == RATE_CNT) begin
              state_d  = FULL;
              nbytes_d = RATE_CNT;
              last_d   = 1'b0;
            end else begin
              state_d = FILL;
            end
          end else begin
            state_d = FILL;
          end
        end
        FULL: begin
          if (blk_take_s) begin
            if (pad_pend_q) begin
              acc_d      = {56'd0, PAD_BYTE, 64'd0};
              nbytes_d   = 5'd0;
              last_d     = 1'b1;
              pad_pend_d = 1'b0;
              state_d    = FULL;
            end else begin
              acc_d    = 128'd0;
              cnt_d    = 5'd0;
              nbytes_d = 5'd0;
              last_d   = 1'b0;
              state_d  = FILL;
            end
          end else begin
            state_d = FULL;
          end
        end
        default: begin
          state_d    = FILL;
          cnt_d      = 5'd0;
          acc_d      = 128'd0;
          nbytes_d   = 5'd0;
          last_d     = 1'b0;
          pad_pend_d = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= FILL;
      cnt_q      <= 5'd0;
      acc_q      <= 128'd0;
      nbytes_q   <= 5'd0;
      last_q     <= 1'b0;
      pad_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      nbytes_q   <= nbytes_d;
      last_q     <= last_d;
      pad_pend_q <= pad_pend_d;
    end
  end

endmodule

// File: tb/tb_ascon_block_packer.sv
// Directed and randomized bench for ascon_block_packer against a message-level padding model.
module tb_ascon_block_packer;

  localparam int IB    = 4;
  localparam int LIMIT = 2000;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   nb;
    logic         last;
  } blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  ascon_block_packer_if #(.IN_BYTES(IB)) bus ();

  ascon_block_packer #(.IN_BYTES(IB)) dut (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  logic [7:0]   msg_q[$];
  blk_t         exp_q[$];
  logic [127:0] last_obs;
  logic [4:0]   last_nb;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // S0 holds stream bytes 0..7, S1 bytes 8..15, each little-endian; blk = {S0, S1}.
  function automatic logic [127:0] pack(input logic [7:0] b [16]);
    logic [63:0] s0, s1;
    for (int i = 0; i < 8; i++) begin
      s0[8*i +: 8] = b[i];
      s1[8*i +: 8] = b[8+i];
    end
    return {s0, s1};
  endfunction

  // Full 16-byte chunks, then a final block holding the remainder plus 0x01.
  task automatic build_model();
    logic [7:0] b [16];
    int len, pos, rem;
    blk_t e;
    exp_q.delete();
    len = msg_q.size();
    pos = 0;
    while (len - pos >= 16) begin
      for (int i = 0; i < 16; i++) b[i] = msg_q[pos+i];
      e.data = pack(b); e.nb = 5'd16; e.last = 1'b0;
      exp_q.push_back(e);
      pos += 16;
    end
    rem = len - pos;
    for (int i = 0; i < 16; i++) begin
      if (i < rem)       b[i] = msg_q[pos+i];
      else if (i == rem) b[i] = 8'h01;
      else               b[i] = 8'h00;
    end
    e.data = pack(b); e.nb = 5'(rem); e.last = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drive_word(input int wi, input int nwords);
    int base;
    base = wi * IB;
    for (int j = 0; j < IB; j++) begin
      if (base + j < msg_q.size()) begin
        bus.s_data[8*j +: 8] = msg_q[base+j];
        bus.s_keep[j]        = 1'b1;
      end else begin
        bus.s_data[8*j +: 8] = 8'($urandom);
        bus.s_keep[j]        = 1'b0;
      end
    end
    bus.s_last  = (wi == nwords - 1);
    bus.s_valid = 1'b1;
  endtask

  // Streams one message (random or 00,01,.. bytes) and checks every emitted block.
  task automatic run_msg(input int len, input bit rnd, input int stall, input int busy_pct);
    int   nwords, wi, cyc, stall_left;
    bit   have_snap;
    blk_t snap, e;
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(rnd ? 8'($urandom) : 8'(i));
    build_model();
    nwords     = (len == 0) ? 1 : (len + IB - 1) / IB;
    wi         = 0;
    cyc        = 0;
    stall_left = stall;
    have_snap  = 1'b0;
    while ((wi < nwords || exp_q.size() != 0) && cyc < LIMIT) begin
      if (wi < nwords && $urandom_range(99) >= 32'(busy_pct / 2)) drive_word(wi, nwords);
      else bus.s_valid = 1'b0;
      if (bus.blk_valid && stall_left > 0) bus.blk_ready = 1'b0;
      else bus.blk_ready = ($urandom_range(99) >= 32'(busy_pct));
      #1;
      if (bus.blk_valid && stall_left > 0) begin
        if (!have_snap) begin
          snap.data = bus.blk_data; snap.nb = bus.blk_nbytes; snap.last = bus.blk_last;
          have_snap = 1'b1;
        end else begin
          chk("stall_data", bus.blk_data, snap.data);
          chk("stall_nbytes", 128'(bus.blk_nbytes), 128'(snap.nb));
          chk("stall_last", 128'(bus.blk_last), 128'(snap.last));
        end
        chk("stall_s_ready", 128'(bus.s_ready), 128'(1'b0));
        stall_left--;
      end
      if (bus.blk_valid && bus.blk_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_blk", 128'(bus.blk_valid), 128'(1'b0));
        end else begin
          e = exp_q.pop_front();
          chk("blk_data", bus.blk_data, e.data);
          chk("blk_nbytes", 128'(bus.blk_nbytes), 128'(e.nb));
          chk("blk_last", 128'(bus.blk_last), 128'(e.last));
          last_obs = bus.blk_data;
          last_nb  = bus.blk_nbytes;
        end
      end
      if (bus.s_valid && bus.s_ready) wi++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.s_valid   = 1'b0;
    bus.blk_ready = 1'b0;
    chk("words_consumed", 128'(wi), 128'(nwords));
    chk("blocks_pending", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    bus.s_data    = '0;
    bus.s_keep    = '0;
    bus.s_last    = 1'b0;
    bus.s_valid   = 1'b0;
    bus.blk_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_s_ready", 128'(bus.s_ready), 128'(1'b0));
    chk("rst_blk_valid", 128'(bus.blk_valid), 128'(1'b0));
    chk("rst_blk_data", bus.blk_data, 128'd0);
    chk("rst_blk_nbytes", 128'(bus.blk_nbytes), 128'(5'd0));
    chk("rst_blk_last", 128'(bus.blk_last), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("fill_s_ready", 128'(bus.s_ready), 128'(1'b1));
    @(negedge clk);

    // 1: 32-byte AD -> two full blocks and a pad-only block
    run_msg(32, 1'b1, 0, 0);
    chk("t1_pad_blk", last_obs, {64'h01, 64'h0});

    // 2: 5-byte message 00..04
    run_msg(5, 1'b0, 0, 0);
    chk("t2_s0", 128'(last_obs[127:64]), 128'(64'h0000_0104_0302_0100));
    chk("t2_s1", 128'(last_obs[63:0]), 128'(64'h0));

    // 3: empty message
    run_msg(0, 1'b1, 0, 0);
    chk("t3_pad_blk", last_obs, {64'h01, 64'h0});
    chk("t3_nbytes", 128'(last_nb), 128'(5'd0));

    // 4: backpressure on a full block, then a 20-byte message
    run_msg(16, 1'b1, 10, 0);
    run_msg(20, 1'b1, 0, 0);
    chk("t4_nbytes", 128'(last_nb), 128'(5'd4));
    chk("t4_pad_lane4", 128'(last_obs[96 +: 8]), 128'(8'h01));

    // 5: clear after three words, asserted with a block-completing fourth word
    for (int w = 0; w < 4; w++) begin
      bus.s_data  = IB * 8'($urandom);
      bus.s_data  = 32'($urandom);
      bus.s_keep  = '1;
      bus.s_last  = 1'b0;
      bus.s_valid = 1'b1;
      clear       = (w == 3);
      #1;
      chk("t5_s_ready", 128'(bus.s_ready), 128'(1'b1));
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    clear       = 1'b0;
    #1;
    chk("t5_blk_valid", 128'(bus.blk_valid), 128'(1'b0));
    chk("t5_acc_cleared", bus.blk_data, 128'd0);
    @(negedge clk);
    run_msg(16, 1'b1, 0, 0);

    // 6: async reset while a full block waits
    for (int w = 0; w < 4; w++) begin
      bus.s_data  = 32'($urandom) | 32'h1;
      bus.s_keep  = '1;
      bus.s_last  = 1'b0;
      bus.s_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    #1;
    chk("t6_full_before_rst", 128'(bus.blk_valid), 128'(1'b1));
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_blk_valid", 128'(bus.blk_valid), 128'(1'b0));
    chk("t6_rst_blk_data", bus.blk_data, 128'd0);
    chk("t6_rst_nbytes", 128'(bus.blk_nbytes), 128'(5'd0));
    chk("t6_rst_s_ready", 128'(bus.s_ready), 128'(1'b0));
    #1;
    rst = 1'b0;
    @(negedge clk);
    run_msg(8, 1'b1, 0, 0);
    chk("t6_s1_pad", 128'(last_obs[63:0]), 128'(64'h01));
    chk("t6_nbytes", 128'(last_nb), 128'(5'd8));

    // Random lengths with random stalls on both sides
    for (int r = 0; r < 12; r++) begin
      run_msg(int'($urandom_range(50)), 1'b1, int'($urandom_range(3)), 30);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
